// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding and entry field layout for the writeback trace buffer
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 12;
  localparam int DEF_REG_W  = 5;

  // Entry layout, MSB to LSB: {pc, reg, data}
  function automatic int entry_w(input int pc_w, input int reg_w, input int data_w);
    return pc_w + reg_w + data_w;
  endfunction

  function automatic int reg_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pc_lsb(input int reg_w, input int data_w);
    return reg_w + data_w;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// rtl/pipeline_trace_buffer_if.sv - regfile capture tap and readout stream bundle
interface pipeline_trace_buffer_if #(
  parameter int PC_W   = 12,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              cap_we;
  logic [PC_W-1:0]   cap_pc;
  logic [REG_W-1:0]  cap_reg;
  logic [DATA_W-1:0] cap_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (
    output cap_we, cap_pc, cap_reg, cap_data, rd_ready,
    input  rd_valid, rd_pc, rd_reg, rd_data, rd_last
  );

  modport slave (
    input  cap_we, cap_pc, cap_reg, cap_data, rd_ready,
    output rd_valid, rd_pc, rd_reg, rd_data, rd_last
  );
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - flop-array ring storage, one write port and one asynchronous read port
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 49,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data storage carries no reset; validity is tracked by the fill counter upstream
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - PC-triggered regfile writeback trace capture with drain port
import trace_pkg::*;

module pipeline_trace_buffer #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PC_W      = DEF_PC_W,
  parameter int REG_W     = DEF_REG_W,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            abort,
  input  logic            trig_en,
  input  logic [PC_W-1:0] trig_pc,
  pipeline_trace_buffer_if.slave bus,
  output logic            wrapped,
  output logic            busy,
  output logic            done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENTRY_W = entry_w(PC_W, REG_W, DATA_W);
  localparam int REG_LSB = reg_lsb(DATA_W);
  localparam int PC_LSB  = pc_lsb(REG_W, DATA_W);

  state_t             state_q, state_n;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
  logic [FILL_W-1:0]  fill_q, fill_n;
  logic [PTR_W-1:0]   post_q, post_n;
  logic               wrapped_q, wrapped_n;
  logic               busy_q, done_q;
  logic               ram_we;
  logic               trig_hit;
  logic               rd_valid;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign trig_hit = trig_en & bus.cap_we & (bus.cap_pc == trig_pc);
  assign wdata    = {bus.cap_pc, bus.cap_reg, bus.cap_data};

  always_comb begin
    state_n   = state_q;
    wr_ptr_n  = wr_ptr_q;
    rd_ptr_n  = rd_ptr_q;
    fill_n    = fill_q;
    post_n    = post_q;
    wrapped_n = wrapped_q;
    ram_we    = 1'b0;
    if (abort) begin
      state_n = IDLE;
      fill_n  = '0;
      post_n  = '0;
    end else if (arm) begin
      state_n   = ARMED;
      wr_ptr_n  = '0;
      fill_n    = '0;
      post_n    = '0;
      wrapped_n = 1'b0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (bus.cap_we) begin
            ram_we   = 1'b1;
            wr_ptr_n = wr_ptr_q + 1'b1;
            if (fill_q == FILL_W'(DEPTH)) wrapped_n = 1'b1;
            else                          fill_n    = fill_q + 1'b1;
            if (state_q == ARMED) begin
              if (trig_hit) begin
                if (POST_TRIG == 0) state_n = DRAIN;
                else begin
                  state_n = POST;
                  post_n  = PTR_W'(POST_TRIG);
                end
              end
            end else begin
              post_n = post_q - 1'b1;
              if (post_q == PTR_W'(1)) state_n = DRAIN;
            end
            // Oldest surviving entry sits fill slots behind the write pointer
            rd_ptr_n = wr_ptr_n - fill_n[PTR_W-1:0];
          end
        end
        DRAIN: begin
          if (rd_valid && bus.rd_ready) begin
            rd_ptr_n = rd_ptr_q + 1'b1;
            fill_n   = fill_q - 1'b1;
            if (fill_q == FILL_W'(1)) state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      post_q    <= '0;
      wrapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      fill_q    <= fill_n;
      post_q    <= post_n;
      wrapped_q <= wrapped_n;
      busy_q    <= (state_n == ARMED) || (state_n == POST);
      done_q    <= (state_n == DRAIN);
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Readout fields are forced to zero outside a valid beat so stale RAM never leaks out
  assign rd_valid     = (state_q == DRAIN) && (fill_q != '0);
  assign bus.rd_valid = rd_valid;
  assign bus.rd_last  = rd_valid && (fill_q == FILL_W'(1));
  assign bus.rd_pc    = rd_valid ? rdata[PC_LSB +: PC_W]    : '0;
  assign bus.rd_reg   = rd_valid ? rdata[REG_LSB +: REG_W]  : '0;
  assign bus.rd_data  = rd_valid ? rdata[0 +: DATA_W]       : '0;

  assign wrapped = wrapped_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - scoreboard bench for the writeback trace buffer
module tb_pipeline_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 12;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic arm, arm0, abort, abort0, trig_en;
  logic [PC_W-1:0]   trig_pc;
  logic              cap_we;
  logic [PC_W-1:0]   cap_pc;
  logic [REG_W-1:0]  cap_reg;
  logic [DATA_W-1:0] cap_data;
  logic              rd_ready;
  logic              sel;
  logic wrapped, busy, done, wrapped0, busy0, done0;

  ent_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipeline_trace_buffer_if #(.PC_W(PC_W), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();
  pipeline_trace_buffer_if #(.PC_W(PC_W), .REG_W(REG_W), .DATA_W(DATA_W)) bus0 ();

  assign bus.cap_we    = cap_we;
  assign bus.cap_pc    = cap_pc;
  assign bus.cap_reg   = cap_reg;
  assign bus.cap_data  = cap_data;
  assign bus.rd_ready  = rd_ready & ~sel;
  assign bus0.cap_we   = cap_we;
  assign bus0.cap_pc   = cap_pc;
  assign bus0.cap_reg  = cap_reg;
  assign bus0.cap_data = cap_data;
  assign bus0.rd_ready = rd_ready & sel;

  pipeline_trace_buffer #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .DEPTH(DEPTH), .POST_TRIG(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_en(trig_en),
    .trig_pc(trig_pc), .bus(bus), .wrapped(wrapped), .busy(busy), .done(done)
  );

  pipeline_trace_buffer #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .DEPTH(DEPTH), .POST_TRIG(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm0), .abort(abort0), .trig_en(trig_en),
    .trig_pc(trig_pc), .bus(bus0), .wrapped(wrapped0), .busy(busy0), .done(done0)
  );

  wire              rv   = sel ? bus0.rd_valid : bus.rd_valid;
  wire              rl   = sel ? bus0.rd_last  : bus.rd_last;
  wire [PC_W-1:0]   rpc  = sel ? bus0.rd_pc    : bus.rd_pc;
  wire [REG_W-1:0]  rreg = sel ? bus0.rd_reg   : bus.rd_reg;
  wire [DATA_W-1:0] rdat = sel ? bus0.rd_data  : bus.rd_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input int pc, input bit model);
    ent_t e;
    @(negedge clk);
    cap_we   = 1'b1;
    cap_pc   = PC_W'(pc);
    cap_reg  = REG_W'($urandom);
    cap_data = $urandom;
    e = '{pc: cap_pc, rg: cap_reg, d: cap_data};
    if (model) begin
      sb.push_back(e);
      if (sb.size() > DEPTH) void'(sb.pop_front());
    end
    @(negedge clk);
    cap_we = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    if (sel) arm0 = 1'b1; else arm = 1'b1;
    sb.delete();
    @(negedge clk);
    arm  = 1'b0;
    arm0 = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort  = 1'b1;
    abort0 = 1'b1;
    sb.delete();
    @(negedge clk);
    abort  = 1'b0;
    abort0 = 1'b0;
  endtask

  task automatic drain(input int max_pops, input bit toggle, output int pops);
    ent_t e;
    pops = 0;
    for (int c = 0; c < 200 && pops < max_pops; c++) begin
      @(negedge clk);
      if (!rv) break;
      rd_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (sb.size() == 0) begin
        check("extra_entry", 64'(rpc), 64'hffff_ffff);
        break;
      end
      e = sb[0];
      check("rd_pc",   64'(rpc),  64'(e.pc));
      check("rd_reg",  64'(rreg), 64'(e.rg));
      check("rd_data", 64'(rdat), 64'(e.d));
      check("rd_last", 64'(rl),   64'(sb.size() == 1));
      if (rd_ready) begin
        void'(sb.pop_front());
        pops++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  int pops;

  initial begin
    rst_n = 1'b0; arm = 0; arm0 = 0; abort = 0; abort0 = 0; trig_en = 0; trig_pc = '0;
    cap_we = 0; cap_pc = '0; cap_reg = '0; cap_data = '0; rd_ready = 0; sel = 0;

    // Reset with random inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      arm = 1'($urandom); trig_en = 1'($urandom); cap_we = 1'($urandom);
      cap_pc = PC_W'($urandom); rd_ready = 1'($urandom); abort = 1'($urandom);
      @(posedge clk); #1;
      check("rst_valid", 64'(bus.rd_valid), 0);
      check("rst_busy",  64'(busy), 0);
      check("rst_done",  64'(done), 0);
      check("rst_wrap",  64'(wrapped), 0);
      check("rst_pc",    64'(bus.rd_pc), 0);
      check("rst_last",  64'(bus.rd_last), 0);
      check("rst_state", 64'(u_dut.state_q), 64'(IDLE));
    end
    @(negedge clk);
    arm = 0; abort = 0; trig_en = 0; cap_we = 0; rd_ready = 0;
    rst_n = 1'b1;
    cap(5, 1'b0);
    cap(6, 1'b0);
    check("idle_fill",  64'(u_dut.fill_q), 0);
    check("idle_state", 64'(u_dut.state_q), 64'(IDLE));

    // No wrap: trigger at pc 3, four post entries
    trig_en = 1'b1; trig_pc = 12'd3;
    pulse_arm();
    check("t2_busy", 64'(busy), 1);
    for (int p = 1; p <= 3; p++) cap(p, 1'b1);
    check("t2_post", 64'(u_dut.state_q), 64'(POST));
    for (int p = 4; p <= 7; p++) begin
      check("t2_not_done", 64'(done), 0);
      cap(p, 1'b1);
    end
    check("t2_done", 64'(done), 1);
    check("t2_wrap", 64'(wrapped), 0);
    drain(DEPTH, 1'b0, pops);
    check("t2_pops", 64'(pops), 7);
    check("t2_idle", 64'(u_dut.state_q), 64'(IDLE));
    check("t2_done_clr", 64'(done), 0);

    // Wrap: 20 writes, trigger at pc 15
    trig_pc = 12'd15;
    pulse_arm();
    for (int p = 0; p < 20; p++) begin
      if (p == 8) check("t3_wrap_pre", 64'(wrapped), 0);
      cap(p, 1'b1);
    end
    check("t3_done", 64'(done), 1);
    check("t3_wrap", 64'(wrapped), 1);
    check("t3_oldest", 64'(sb[0].pc), 12);
    drain(DEPTH, 1'b0, pops);
    check("t3_pops", 64'(pops), 8);

    // Backpressure with a full ring
    trig_pc = 12'd9;
    pulse_arm();
    for (int p = 0; p < 14; p++) cap(p, 1'b1);
    drain(DEPTH, 1'b1, pops);
    check("t4_pops", 64'(pops), 8);
    check("t4_sb_empty", 64'(sb.size()), 0);
    check("t4_idle", 64'(u_dut.state_q), 64'(IDLE));

    // Arm beats a simultaneous trigger match
    trig_pc = 12'd5;
    pulse_arm();
    cap(1, 1'b1);
    @(negedge clk);
    arm = 1'b1; cap_we = 1'b1; cap_pc = 12'd5;
    @(negedge clk);
    arm = 1'b0; cap_we = 1'b0;
    sb.delete();
    check("t5_state", 64'(u_dut.state_q), 64'(ARMED));
    check("t5_fill",  64'(u_dut.fill_q), 0);
    pulse_abort();

    // Zero post window: trigger entry is the final one
    sel = 1'b1; trig_pc = 12'd2;
    pulse_arm();
    check("t5_busy0", 64'(busy0), 1);
    cap(1, 1'b1);
    check("t5_notdone0", 64'(done0), 0);
    cap(2, 1'b1);
    check("t5_done0", 64'(done0), 1);
    check("t5_wrap0", 64'(wrapped0), 0);
    drain(DEPTH, 1'b0, pops);
    check("t5_pops0", 64'(pops), 2);
    sel = 1'b0;

    // Abort in POST, then re-arm mid-drain
    pulse_arm();
    cap(1, 1'b1);
    cap(2, 1'b1);
    check("t6_post", 64'(u_dut.state_q), 64'(POST));
    pulse_abort();
    check("t6_idle",  64'(u_dut.state_q), 64'(IDLE));
    check("t6_valid", 64'(bus.rd_valid), 0);
    check("t6_busy",  64'(busy), 0);
    pulse_arm();
    for (int p = 1; p <= 6; p++) cap(p, 1'b1);
    check("t6_done", 64'(done), 1);
    drain(2, 1'b0, pops);
    check("t6_pops", 64'(pops), 2);
    check("t6_valid_pre", 64'(bus.rd_valid), 1);
    pulse_arm();
    check("t6_armed", 64'(u_dut.state_q), 64'(ARMED));
    check("t6_fill",  64'(u_dut.fill_q), 0);
    check("t6_valid_post", 64'(bus.rd_valid), 0);
    check("t6_done_clr", 64'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
